// File: rtl/cpu_io_pkg.sv
// Shared word type and change-detect helper for the CPU I/O bridge and the
// host-side models that talk to risc_v.
package cpu_io_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // A new CPU output word is one that differs from the last sampled value,
    // optionally ignoring transitions to zero (idle pin state).
    function automatic logic out_changed(input word_t cur, input word_t prev, input logic skip_zero);
        return (cur != prev) && !(skip_zero && (cur == '0));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and head-of-queue read; a push
// into a full FIFO is accepted only when a pop frees the slot that same cycle.
module sync_fifo
    import cpu_io_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = word_t,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  T                 wdata,
    input  logic             pop,
    output T                 rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Head is read straight from the registered array so a word written at an
    // edge is visible on rdata right after that edge.
    assign rdata = mem[rd_ptr_reg];
    assign count = count_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/cpu_io_bridge.sv
// Host-side bridge for the CPU word I/O pins: queues each new CPUOut value to
// the host and feeds host words into CPUIn with a minimum observation time.
module cpu_io_bridge
    import cpu_io_pkg::*;
#(
    parameter int    FIFO_DEPTH = 8,
    parameter int    SKIP_ZERO  = 1,
    parameter int    IN_HOLD    = 4,
    parameter word_t IN_RESET   = '0
) (
    input  logic                        CLK,
    input  logic                        Reset,
    input  word_t                       CPUOut,
    output word_t                       CPUIn,
    output word_t                       OutData,
    output logic                        OutValid,
    input  logic                        OutReady,
    output logic [$clog2(FIFO_DEPTH):0] OutCount,
    input  word_t                       InData,
    input  logic                        InValid,
    output logic                        InReady,
    output logic                        Overflow
);

    localparam int HOLD_W = (IN_HOLD > 0) ? $clog2(IN_HOLD + 1) : 1;

    word_t             prev_out_reg;
    word_t             cpu_in_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic              overflow_reg;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;

    assign push = out_changed(CPUOut, prev_out_reg, SKIP_ZERO != 0);
    assign pop  = OutValid && OutReady;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (word_t)
    ) u_out_fifo (
        .clk   (CLK),
        .srst  (Reset),
        .push  (push),
        .wdata (CPUOut),
        .pop   (pop),
        .rdata (OutData),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (OutCount)
    );

    assign OutValid = !fifo_empty;

    // prev_out tracks every sample, skipped zeros included, so a return to the
    // previous non-zero value is seen as a fresh change.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            prev_out_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            prev_out_reg <= CPUOut;
            if (push && fifo_full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign Overflow = overflow_reg;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cpu_in_reg   <= IN_RESET;
            hold_cnt_reg <= '0;
        end else if (hold_cnt_reg != '0) begin
            hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
        end else if (InValid) begin
            cpu_in_reg   <= InData;
            hold_cnt_reg <= HOLD_W'(IN_HOLD);
        end
    end

    assign CPUIn   = cpu_in_reg;
    assign InReady = (hold_cnt_reg == '0);

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Directed bench for cpu_io_bridge: stimulus queues expected host words and a
// negedge monitor checks every word the bridge hands over.
module tb_cpu_io_bridge;
    import cpu_io_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset;
    word_t       CPUOut;
    word_t       CPUIn;
    word_t       OutData;
    logic        OutValid;
    logic        OutReady;
    logic [3:0]  OutCount;
    word_t       InData;
    logic        InValid;
    logic        InReady;
    logic        Overflow;

    int    total = 0;
    int    bad   = 0;
    word_t exp_q[$];

    always #5 CLK = ~CLK;

    cpu_io_bridge #(
        .FIFO_DEPTH (8),
        .SKIP_ZERO  (1),
        .IN_HOLD    (4),
        .IN_RESET   (32'h0)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .CPUOut   (CPUOut),
        .CPUIn    (CPUIn),
        .OutData  (OutData),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutCount (OutCount),
        .InData   (InData),
        .InValid  (InValid),
        .InReady  (InReady),
        .Overflow (Overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    // Scoreboard monitor: a word is consumed at the edge following this sample.
    always @(negedge CLK) begin
        if (!Reset && OutValid && OutReady) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_extra actual=%h required=none", OutData);
            end else begin
                check("out_word", OutData, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        OutReady = 1'b1;
        while ((exp_q.size() != 0 || OutValid) && n < 50) begin
            step();
            n++;
        end
        if (n == 50) begin
            total++;
            bad++;
            $display("FAIL %s_timeout actual=%0d required=0 words left", name, exp_q.size());
        end
        check({name, "_count0"}, 32'(OutCount), 32'd0);
    endtask

    initial begin
        Reset    = 1'b1;
        CPUOut   = 32'd5;
        OutReady = 1'b1;
        InValid  = 1'b0;
        InData   = '0;

        // Reset held two cycles with CPUOut=5
        step();
        step();
        Reset = 1'b0;
        check("t1_outvalid", 32'(OutValid), 32'd0);
        check("t1_outcount", 32'(OutCount), 32'd0);
        check("t1_cpuin",    CPUIn,         32'h0);
        check("t1_inready",  32'(InReady),  32'd1);
        check("t1_overflow", 32'(Overflow), 32'd0);
        exp_q.push_back(32'd5);
        step();
        check("t1_first_valid", 32'(OutValid), 32'd1);
        check("t1_first_data",  OutData,       32'd5);
        step();

        // 0 -> 3 -> 3 -> 7
        CPUOut = 32'd0;
        step();
        check("t2_zero_skipped", 32'(OutValid), 32'd0);
        CPUOut = 32'd3;
        exp_q.push_back(32'd3);
        step();
        check("t2_valid3", 32'(OutValid), 32'd1);
        check("t2_data3",  OutData,       32'd3);
        step();
        check("t2_no_dup", 32'(OutValid), 32'd0);
        CPUOut = 32'd7;
        exp_q.push_back(32'd7);
        step();
        check("t2_valid7", 32'(OutValid), 32'd1);
        check("t2_data7",  OutData,       32'd7);
        step();

        // 9 -> 0 -> 9 queues 9 twice
        CPUOut = 32'd9;
        exp_q.push_back(32'd9);
        step();
        CPUOut = 32'd0;
        step();
        CPUOut = 32'd9;
        exp_q.push_back(32'd9);
        step();
        step();
        drain("t3");

        // Nine pushes into an 8-deep FIFO with no consumer
        OutReady = 1'b0;
        for (int i = 0; i < 9; i++) begin
            CPUOut = 32'h100 + 32'(i);
            if (i < 8) exp_q.push_back(32'h100 + 32'(i));
            step();
        end
        check("t4_count_full", 32'(OutCount), 32'd8);
        check("t4_overflow",   32'(Overflow), 32'd1);
        drain("t4a");
        check("t4_overflow_sticky", 32'(Overflow), 32'd1);
        Reset  = 1'b1;
        CPUOut = 32'd0;
        step();
        Reset = 1'b0;
        check("t4_overflow_cleared", 32'(Overflow), 32'd0);

        // Same fill, but the ninth push coincides with a pop
        OutReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            CPUOut = 32'h200 + 32'(i);
            exp_q.push_back(32'h200 + 32'(i));
            step();
        end
        CPUOut   = 32'h208;
        exp_q.push_back(32'h208);
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        check("t4_count_push_pop", 32'(OutCount), 32'd8);
        check("t4_no_overflow",    32'(Overflow), 32'd0);
        drain("t4b");

        // Input path with a 4-cycle hold-off
        InValid = 1'b1;
        InData  = 32'hA5A5_0001;
        step();
        check("t5_cpuin_a", CPUIn, 32'hA5A5_0001);
        InData = 32'hB6B6_0002;
        for (int i = 0; i < 4; i++) begin
            check("t5_hold_inready", 32'(InReady), 32'd0);
            check("t5_hold_cpuin",   CPUIn,        32'hA5A5_0001);
            step();
        end
        check("t5_ready_again", 32'(InReady), 32'd1);
        check("t5_still_a",     CPUIn,        32'hA5A5_0001);
        step();
        check("t5_cpuin_b",   CPUIn,        32'hB6B6_0002);
        check("t5_b_inready", 32'(InReady), 32'd0);
        InValid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("t5_idle_ready", 32'(InReady), 32'd1);

        // Reset with three words queued and the hold-off at 2
        OutReady = 1'b0;
        InValid  = 1'b1;
        InData   = 32'hC0DE_0003;
        CPUOut   = 32'h301;
        step();
        InValid = 1'b0;
        CPUOut  = 32'h302;
        step();
        CPUOut = 32'h303;
        step();
        check("t6_count3",      32'(OutCount), 32'd3);
        check("t6_hold_active", 32'(InReady),  32'd0);
        check("t6_cpuin_c",     CPUIn,         32'hC0DE_0003);
        Reset  = 1'b1;
        CPUOut = 32'd0;
        step();
        Reset = 1'b0;
        check("t6_count0",   32'(OutCount), 32'd0);
        check("t6_outvalid", 32'(OutValid), 32'd0);
        check("t6_inready",  32'(InReady),  32'd1);
        check("t6_cpuin",    CPUIn,         32'h0);
        check("t6_overflow", 32'(Overflow), 32'd0);
        step();
        check("t6_stays_empty", 32'(OutValid), 32'd0);
        check("t6_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
